// File: rtl/sar_pkg.sv
// Shared types and helpers for the successive-approximation search engine.
// Build option: define SAR_EARLY_EXIT_EN to stop the search on a comparator EQ.
package sar_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRIAL = 2'd1,
        DONE  = 2'd2
    } sar_state_e;

    localparam int unsigned SAR_WIDTH = 4;

    // MSB-first seed: only the top bit set
    localparam logic [SAR_WIDTH-1:0] SAR_INIT_GUESS =
        {1'b1, {(SAR_WIDTH-1){1'b0}}};

    // A legal comparator answer raises exactly one of L/EQ/G
    function automatic logic one_hot3(input logic l,
                                      input logic eq,
                                      input logic g);
        return (l ^ eq ^ g) & ~(l & eq & g);
    endfunction

endpackage

// File: rtl/sar_search.sv
// Successive-approximation search: drives comparator A, resolves B MSB first.
// Build option: SAR_EARLY_EXIT_EN ends the search at the step that sees EQ.
module sar_search
    import sar_pkg::*;
#(
    parameter int unsigned WIDTH = SAR_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmp_l,
    input  logic             cmp_eq,
    input  logic             cmp_g,
    output logic [WIDTH-1:0] guess,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             found,
    output logic             err
);

    localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] INIT_GUESS = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [IW-1:0] TOP_IDX = IW'(WIDTH - 1);

    sar_state_e        state_q, state_d;
    logic [WIDTH-1:0]  guess_q, guess_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              found_q, found_d;
    logic              err_q, err_d;
    logic [WIDTH-1:0]  work;

    // Next-state and datapath: one trial bit resolved per TRIAL cycle
    always_comb begin
        state_d  = state_q;
        guess_d  = guess_q;
        result_d = result_q;
        idx_d    = idx_q;
        found_d  = found_q;
        err_d    = err_q;
        work     = guess_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    guess_d  = INIT_GUESS;
                    idx_d    = TOP_IDX;
                    result_d = '0;
                    found_d  = 1'b0;
                    err_d    = 1'b0;
                    state_d  = TRIAL;
                end
            end
            TRIAL: begin
                if (!one_hot3(cmp_l, cmp_eq, cmp_g)) begin
                    err_d    = 1'b1;
                    found_d  = 1'b0;
                    result_d = guess_q;
                    state_d  = DONE;
                end
`ifdef SAR_EARLY_EXIT_EN
                else if (cmp_eq) begin
                    result_d = guess_q;
                    found_d  = 1'b1;
                    state_d  = DONE;
                end
`endif
                else begin
                    if (cmp_g) begin
                        work[idx_q] = 1'b0;
                    end
                    if (idx_q == '0) begin
                        result_d = work;
                        found_d  = 1'b1;
                        state_d  = DONE;
                    end else begin
                        guess_d = work;
                        guess_d[idx_q - IW'(1)] = 1'b1;
                        idx_d = idx_q - IW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == TRIAL);
        done_d = (state_d == DONE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            guess_q  <= '0;
            result_q <= '0;
            idx_q    <= TOP_IDX;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            guess_q  <= guess_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            found_q  <= found_d;
            err_q    <= err_d;
        end
    end

    assign guess  = guess_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign found  = found_q;
    assign err    = err_q;

endmodule
